// File: rtl/column_folder_if.sv
// Handshake bundle for column_folder: block-in channel (8 x 16-bit columns),
// digest-out channel and the delivered-block counter.
interface column_folder_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] final_column0;
    logic [15:0] final_column1;
    logic [15:0] final_column2;
    logic [15:0] final_column3;
    logic [15:0] final_column4;
    logic [15:0] final_column5;
    logic [15:0] final_column6;
    logic [15:0] final_column7;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] fold_out;
    logic [7:0]  block_count;

    modport master (
        output in_valid,
        output final_column0, final_column1, final_column2, final_column3,
        output final_column4, final_column5, final_column6, final_column7,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  fold_out,
        input  block_count
    );

    modport slave (
        input  in_valid,
        input  final_column0, final_column1, final_column2, final_column3,
        input  final_column4, final_column5, final_column6, final_column7,
        input  out_ready,
        output in_ready,
        output out_valid,
        output fold_out,
        output block_count
    );
endinterface

// File: rtl/column_folder.sv
// Folds one block of eight 16-bit columns into a rotate-XOR digest, one column per cycle.
// Optional `COLUMN_FOLDER_CHAIN_EN seeds each fold with the previously delivered digest.
module column_folder (
    input  logic           clk,
    input  logic           rst,
    column_folder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0][15:0] col_q, col_d;
    logic [15:0]      acc_q, acc_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [15:0]      acc_init;
    logic [7:0][15:0] col_in;
    logic             accept;
    logic             deliver;

    assign col_in = {bus.final_column7, bus.final_column6, bus.final_column5, bus.final_column4,
                     bus.final_column3, bus.final_column2, bus.final_column1, bus.final_column0};

    // Held low while rst is asserted so nothing is accepted on a reset edge.
    assign bus.in_ready    = (state_q == IDLE) && !rst;
    assign bus.out_valid   = (state_q == DONE);
    assign bus.fold_out    = acc_q;
    assign bus.block_count = cnt_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign deliver = bus.out_valid && bus.out_ready;

`ifdef COLUMN_FOLDER_CHAIN_EN
    logic [15:0] chain_q, chain_d;

    assign acc_init = chain_q;

    always_comb begin
        chain_d = chain_q;
        if (deliver) chain_d = acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) chain_q <= '0;
        else     chain_q <= chain_d;
    end
`else
    assign acc_init = 16'h0000;
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    col_d   = col_in;
                    acc_d   = acc_init;
                    idx_d   = 3'd0;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                acc_d = {acc_q[14:0], acc_q[15]} ^ col_q[idx_q];
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = DONE;
            end
            DONE: begin
                if (deliver) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_column_folder.sv
// Bench for column_folder: directed table, hand-written reset/back-pressure sequences,
// and random blocks checked against a closed-form digest model.
module tb_column_folder;
    logic clk;
    logic rst;
    column_folder_if bus ();

    column_folder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    logic [15:0] chain_m;
    logic [7:0]  cnt_m;

    typedef struct {
        logic [7:0][15:0] cols;
        logic [15:0]      exp;
    } vec_t;

    vec_t tv[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] v, input int k);
        int s;
        s = k % 16;
        if (s == 0) return v;
        return (v << s) | (v >> (16 - s));
    endfunction

    // Digest = rotl(init,8) ^ XOR_i rotl(col_i, 7-i): each column is rotated once per later step.
    function automatic logic [15:0] model_fold(input logic [7:0][15:0] c, input logic [15:0] init);
        logic [15:0] r;
        r = rotl(init, 8);
        for (int i = 0; i < 8; i++) r = r ^ rotl(c[i], 7 - i);
        return r;
    endfunction

    task automatic set_cols(input logic [7:0][15:0] c);
        bus.final_column0 = c[0];
        bus.final_column1 = c[1];
        bus.final_column2 = c[2];
        bus.final_column3 = c[3];
        bus.final_column4 = c[4];
        bus.final_column5 = c[5];
        bus.final_column6 = c[6];
        bus.final_column7 = c[7];
    endtask

    task automatic rand_cols();
        logic [7:0][15:0] c;
        for (int i = 0; i < 8; i++) c[i] = 16'($urandom);
        set_cols(c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_fold_out", {16'd0, bus.fold_out}, 32'd0);
        check("rst_block_count", {24'd0, bus.block_count}, 32'd0);
        chain_m = 16'h0000;
        cnt_m   = 8'h00;
    endtask

    // Starts at a negedge in IDLE; returns at the negedge after the output handshake.
    task automatic run_block(input logic [7:0][15:0] cols, input int hold, output logic [15:0] got);
        logic [15:0] exp;
        int n;
        exp = model_fold(cols, chain_m);
        bus.out_ready = (hold == 0);
        set_cols(cols);
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        n = 1;
        while (!bus.out_valid && n < 20) begin
            bus.in_valid = 1'($urandom);
            rand_cols();
            @(negedge clk);
            n++;
        end
        check("latency_edges", n, 32'd9);
        got = bus.fold_out;
        check("fold_out", {16'd0, got}, {16'd0, exp});
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'($urandom);
            @(negedge clk);
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_fold_out", {16'd0, bus.fold_out}, {16'd0, exp});
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_block_count", {24'd0, bus.block_count}, {24'd0, cnt_m});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        cnt_m = cnt_m + 8'd1;
`ifdef COLUMN_FOLDER_CHAIN_EN
        chain_m = exp;
`endif
        check("post_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("post_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("block_count", {24'd0, bus.block_count}, {24'd0, cnt_m});
    endtask

    initial begin
        logic [15:0] got;
        logic [7:0][15:0] c;
        vectors       = 0;
        miscompares   = 0;
        chain_m       = 16'h0000;
        cnt_m         = 8'h00;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_cols('0);

        for (int i = 0; i < 6; i++) tv[i].cols = '0;
        tv[0].exp = 16'h0000;
        tv[1].cols[0] = 16'h0001;   tv[1].exp = 16'h0080;
        tv[2].cols[7] = 16'h0001;   tv[2].exp = 16'h0001;
        for (int i = 0; i < 8; i++) tv[3].cols[i] = 16'hFFFF;
        tv[3].exp = 16'h0000;
        tv[4].cols[1] = 16'h0001;   tv[4].exp = 16'h0040;
        tv[5].cols[0] = 16'h8000;   tv[5].cols[6] = 16'h0003;
        tv[5].exp = 16'h0046;

        // Directed table, each from a fresh reset so chaining does not disturb the constants.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            run_block(tv[i].cols, 0, got);
            check("table_digest", {16'd0, got}, {16'd0, tv[i].exp});
        end

        // Chaining: column0=1 twice.
        do_reset();
        c = '0;
        c[0] = 16'h0001;
        run_block(c, 0, got);
        check("chain_first", {16'd0, got}, 32'h0080);
        run_block(c, 0, got);
`ifdef COLUMN_FOLDER_CHAIN_EN
        check("chain_second", {16'd0, got}, 32'h8080);
`else
        check("chain_second", {16'd0, got}, 32'h0080);
`endif

        // Back-pressure for 5 cycles with in_valid pulses.
        c[3] = 16'hA5C3;
        run_block(c, 5, got);

        // Reset in the 4th FOLD cycle.
        c = '0;
        c[0] = 16'h1234;
        set_cols(c);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_fold_out", {16'd0, bus.fold_out}, 32'd0);
        check("midrst_block_count", {24'd0, bus.block_count}, 32'd0);
        chain_m = 16'h0000;
        cnt_m   = 8'h00;
        c = '0;
        c[0] = 16'h0001;
        run_block(c, 0, got);
        check("midrst_chain_cleared", {16'd0, got}, 32'h0080);

        // Reset together with out_ready in DONE: count must stay 0.
        do_reset();
        bus.out_ready = 1'b0;
        set_cols(c);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("rstdone_out_valid", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstdone_block_count", {24'd0, bus.block_count}, 32'd0);
        check("rstdone_out_valid_low", {31'd0, bus.out_valid}, 32'd0);
        chain_m = 16'h0000;
        cnt_m   = 8'h00;

        // 256 random blocks: wrap of block_count plus random data and back-pressure.
        for (int b = 0; b < 256; b++) begin
            for (int i = 0; i < 8; i++) c[i] = 16'($urandom);
            run_block(c, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, got);
        end
        check("wrap_block_count", {24'd0, bus.block_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
